instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port fetch_en  input  1: 1 = issue fetches; 0 = stop issuing.
REQ-007 SHALL have port br_valid  input  1: redirect request, single-cycle pulse.
REQ-008 SHALL have port br_target  input  ADDR_W: redirect word address.
REQ-009 SHALL have port im_cen  output  1: IMEM chip enable, active-low.
REQ-010 SHALL have port im_wen  output  1: IMEM write enable, active-low, tied 1.
REQ-011 SHALL have port im_oen  output  1: IMEM output enable, active-low.
REQ-012 SHALL have port im_addr  output  ADDR_W: IMEM word address.
REQ-013 SHALL have port im_dataout  input  DATA_W: IMEM read data, valid the cycle after a request.
REQ-014 SHALL have port if_valid  output  1: if_instr/if_pc hold a valid instruction.
REQ-015 SHALL have port id_ready  input  1: decode accepts; transfer = if_valid & id_ready.
REQ-016 SHALL have port if_instr  output  DATA_W: instruction word.
REQ-017 SHALL have port if_pc  output  ADDR_W: address of if_instr.
REQ-018 SHALL have port fetch_cnt  output  32: count of completed transfers.

Function
REQ-019 SHALL implement FSM IDLE/RUN: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; in IDLE, no requests are issued.
REQ-020 SHALL issue a request (im_cen=0, im_oen=0) in a cycle iff state=RUN, fetch_en=1 and (buffer count + in-flight - pop this cycle) < 2; otherwise im_cen=1, im_oen=1.
REQ-021 SHALL drive im_addr combinationally: br_target when br_valid=1, else pc.
REQ-022 SHALL advance pc to im_addr+1 (mod 2^ADDR_W, 2047 wraps to 0) on each issued request.
REQ-023 SHALL capture im_dataout, paired with the address of its request, into a 2-entry FIFO one cycle after the request; if_valid/if_instr/if_pc SHALL present the FIFO head.
REQ-024 SHALL give a latency of 2 cycles from request cycle to if_valid with empty FIFO: request in cycle t, if_valid in cycle t+2.
REQ-025 SHALL provide sustained throughput of one instruction per cycle while id_ready=1.
REQ-026 SHALL NOT overflow the FIFO: with id_ready=0 it holds at most 2 entries and issue stops; if_instr/if_pc stay stable while if_valid=1 and id_ready=0.
REQ-027 SHALL, on br_valid=1: complete a transfer occurring in the same cycle; flush all other FIFO entries; discard memory data returning in that cycle; set pc per REQ-022 if a request issues, else pc=br_target.
REQ-028 SHALL, on br_valid=1 in IDLE, load pc=br_target with no request.
REQ-029 SHALL let in-flight data complete into the FIFO when fetch_en falls and no redirect occurs.
REQ-030 SHALL increment fetch_cnt by 1 per transfer, wrapping at 2^32.

Reset
REQ-031 SHALL, when rst=1 at a clock edge: state=IDLE, pc=RESET_PC, FIFO empty, in-flight cleared, fetch_cnt=0, if_valid=0; im_cen=1, im_oen=1, im_wen=1 in the following cycle.
REQ-032 SHALL let rst override fetch_en and br_valid in the same cycle; an in-flight return is discarded and the first request after reset is to RESET_PC.

Verification
REQ-033 SHALL be verified with: IMEM[i]=0x1000_0000+i, rst then fetch_en=1, id_ready=1 -> if_pc 0,1,2,... one per cycle from the 3rd cycle after fetch_en, if_instr=0x1000_0000+if_pc.
REQ-034 SHALL be verified with: id_ready=0 for 5 cycles mid-stream -> if_valid=1, if_pc constant, at most 2 requests issued after stall start, no lost or duplicated pc on release.
REQ-035 SHALL be verified with: br_valid pulse with br_target=100 while streaming -> im_addr=100 that cycle, next delivered if_pc=100 then 101, no stale pc delivered.
REQ-036 SHALL be verified with: RESET_PC=2046, stream -> if_pc 2046, 2047, 0, 1.
REQ-037 SHALL be verified with: rst asserted mid-stream with full FIFO -> if_valid=0 and fetch_cnt=0 next cycle; first request after fetch_en addresses RESET_PC.
REQ-038 SHALL be verified with: 10 transfers then fetch_en=0 -> fetch_cnt=10 after drain, in-flight word delivered, im_cen=1 thereafter.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues IMEM reads from a PC and buffers returned
// words in a 2-entry FIFO toward decode, with redirect and flow control.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 11,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              im_cen,
    output logic              im_wen,
    output logic              im_oen,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_dataout,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       fcnt_q, fcnt_d;
    logic [DATA_W-1:0] fifo_instr_q [2];
    logic [ADDR_W-1:0] fifo_pc_q [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ;

    // Occupancy counts slots already promised: buffered plus in flight.
    assign pop   = (cnt_q != 2'd0) && id_ready;
    assign push  = infl_q && !br_valid;
    assign occ   = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign issue = (state_q == RUN) && fetch_en && (occ < 3'd2);

    assign im_addr  = br_valid ? br_target : pc_q;
    assign im_cen   = !issue;
    assign im_oen   = !issue;
    assign im_wen   = 1'b1;
    assign if_valid = (cnt_q != 2'd0);
    assign if_instr = fifo_instr_q[rd_q];
    assign if_pc    = fifo_pc_q[rd_q];
    assign fetch_cnt = fcnt_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_d    = issue;
        infl_pc_d = im_addr;
        rd_d      = rd_q ^ pop;
        wr_d      = wr_q ^ push;
        cnt_d     = cnt_q + 2'(push) - 2'(pop);
        fcnt_d    = fcnt_q + 32'(pop);

        unique case (state_q)
            IDLE: if (fetch_en)  state_d = RUN;
            RUN:  if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            pc_d = im_addr + ADDR_W'(1);
        end else if (br_valid) begin
            pc_d = br_target;
        end

        // A redirect drops everything buffered after the head transfer.
        if (br_valid) begin
            rd_d  = 1'b0;
            wr_d  = 1'b0;
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= ADDR_W'(RESET_PC);
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= 2'd0;
            fcnt_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_instr_q[wr_q] <= im_dataout;
            fifo_pc_q[wr_q]    <= infl_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0 and 2046) checked
// every cycle against a queue-based model, plus directed literal scenarios.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        br_valid = 1'b0;
    logic [10:0] br_target = '0;
    logic        id_ready = 1'b0;

    logic [1:0]  im_cen, im_wen, im_oen, if_valid;
    logic [10:0] im_addr [2];
    logic [10:0] if_pc [2];
    logic [31:0] if_instr [2];
    logic [31:0] fetch_cnt [2];
    logic [31:0] dout [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(11), .DATA_W(32), .RESET_PC(0)) u0 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .br_valid(br_valid), .br_target(br_target),
        .im_cen(im_cen[0]), .im_wen(im_wen[0]), .im_oen(im_oen[0]),
        .im_addr(im_addr[0]), .im_dataout(dout[0]),
        .if_valid(if_valid[0]), .id_ready(id_ready),
        .if_instr(if_instr[0]), .if_pc(if_pc[0]), .fetch_cnt(fetch_cnt[0])
    );

    instr_fetch_unit #(.ADDR_W(11), .DATA_W(32), .RESET_PC(2046)) u1 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .br_valid(br_valid), .br_target(br_target),
        .im_cen(im_cen[1]), .im_wen(im_wen[1]), .im_oen(im_oen[1]),
        .im_addr(im_addr[1]), .im_dataout(dout[1]),
        .if_valid(if_valid[1]), .id_ready(id_ready),
        .if_instr(if_instr[1]), .if_pc(if_pc[1]), .fetch_cnt(fetch_cnt[1])
    );

    function automatic logic [31:0] imem(input int unsigned a);
        return 32'h1000_0000 + a;
    endfunction

    // Synchronous-read memory: data appears the cycle after the request.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (im_cen[k] == 1'b0) dout[k] <= imem(32'(im_addr[k]));
    end

    // Reference model: queue of delivered PCs, one pending request slot.
    int unsigned rp [2] = '{0, 2046};
    int unsigned mq [2][$];
    bit          mrun [2] = '{0, 0};
    int unsigned mpc [2] = '{0, 0};
    bit          minfl [2] = '{0, 0};
    int unsigned minfl_pc [2] = '{0, 0};
    logic [31:0] mcnt [2] = '{0, 0};

    function automatic bit m_pop(input int k);
        return (mq[k].size() > 0) && id_ready;
    endfunction

    function automatic bit m_issue(input int k);
        int pending;
        pending = mq[k].size() + int'(minfl[k]) - int'(m_pop(k));
        return mrun[k] && fetch_en && (pending < 2);
    endfunction

    function automatic int unsigned m_addr(input int k);
        return br_valid ? 32'(br_target) : mpc[k];
    endfunction

    task automatic model_step(input int k);
        bit          pop;
        bit          iss;
        int unsigned a;
        pop = m_pop(k);
        iss = m_issue(k);
        a   = m_addr(k);
        if (rst) begin
            mrun[k]  = 0;
            mpc[k]   = rp[k];
            mq[k].delete();
            minfl[k] = 0;
            mcnt[k]  = 0;
        end else begin
            if (pop) begin
                void'(mq[k].pop_front());
                mcnt[k] = mcnt[k] + 1;
            end
            if (br_valid) mq[k].delete();
            else if (minfl[k]) mq[k].push_back(minfl_pc[k]);
            minfl[k]    = iss;
            minfl_pc[k] = a;
            if (iss) mpc[k] = (a + 1) % 2048;
            else if (br_valid) mpc[k] = 32'(br_target);
            mrun[k] = fetch_en;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit iss;
                iss = m_issue(k);
                chk($sformatf("u%0d.if_valid", k), 32'(if_valid[k]),
                    32'(mq[k].size() > 0));
                if (mq[k].size() > 0) begin
                    chk($sformatf("u%0d.if_pc", k), 32'(if_pc[k]), mq[k][0]);
                    chk($sformatf("u%0d.if_instr", k), if_instr[k],
                        imem(mq[k][0]));
                end
                chk($sformatf("u%0d.im_cen", k), 32'(im_cen[k]), 32'(!iss));
                chk($sformatf("u%0d.im_oen", k), 32'(im_oen[k]), 32'(!iss));
                chk($sformatf("u%0d.im_wen", k), 32'(im_wen[k]), 32'd1);
                if (iss)
                    chk($sformatf("u%0d.im_addr", k), 32'(im_addr[k]),
                        m_addr(k));
                chk($sformatf("u%0d.fetch_cnt", k), fetch_cnt[k], mcnt[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        cyc();
        chk_en = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst.if_valid", 32'(if_valid), 32'd0);
        chk("rst.fetch_cnt", fetch_cnt[0], 32'd0);
        chk("rst.im_cen", 32'(im_cen), 32'd3);

        // Stream from reset: first delivery three cycles after fetch_en.
        cyc();
        rst = 1'b0;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream.valid", 32'(if_valid), 32'd3);
            chk("stream.pc0", 32'(if_pc[0]), 32'(i));
            chk("stream.instr0", if_instr[0], 32'h1000_0000 + 32'(i));
            chk("wrap.pc1", 32'(if_pc[1]), (2046 + i) % 2048);
            cyc();
        end

        // Decode stall for five cycles.
        id_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.valid", 32'(if_valid[0]), 32'd1);
            chk("stall.pc", 32'(if_pc[0]), 32'd4);
            if (im_cen[0] == 1'b0) n++;
            cyc();
        end
        chk("stall.req_le2", 32'(n <= 2), 32'd1);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("release.pc", 32'(if_pc[0]), 32'(4 + i));
            cyc();
        end

        // Redirect to 100 while streaming.
        br_valid = 1'b1;
        br_target = 11'd100;
        @(negedge clk);
        chk("br.im_addr", 32'(im_addr[0]), 32'd100);
        chk("br.im_cen", 32'(im_cen[0]), 32'd0);
        cyc();
        br_valid = 1'b0;
        @(negedge clk);
        chk("br.bubble", 32'(if_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("br.pc100", 32'(if_pc[0]), 32'd100);
        chk("br.pc100_u1", 32'(if_pc[1]), 32'd100);
        cyc();
        @(negedge clk);
        chk("br.pc101", 32'(if_pc[0]), 32'd101);

        // Reset with a full FIFO.
        cyc();
        id_ready = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("full.valid", 32'(if_valid[0]), 32'd1);
        chk("full.no_req", 32'(im_cen[0]), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("rst2.valid", 32'(if_valid), 32'd0);
        chk("rst2.fetch_cnt", fetch_cnt[0], 32'd0);
        cyc();
        @(negedge clk);
        chk("rst2.req", 32'(im_cen), 32'd0);
        chk("rst2.addr0", 32'(im_addr[0]), 32'd0);
        chk("rst2.addr1", 32'(im_addr[1]), 32'd2046);

        // Exactly ten requests, then drop fetch_en and let it drain.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        fetch_en = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (im_cen[0] == 1'b0) n++;
            if (n == 10) break;
        end
        chk("drain.req10", 32'(n), 32'd10);
        cyc();
        fetch_en = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("drain.cnt0", fetch_cnt[0], 32'd10);
        chk("drain.cnt1", fetch_cnt[1], 32'd10);
        chk("drain.idle", 32'(im_cen), 32'd3);
        chk("drain.empty", 32'(if_valid), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            fetch_en = ($urandom_range(0, 9) != 0);
            br_valid = ($urandom_range(0, 19) == 0);
            br_target = $urandom_range(0, 1) ? 11'($urandom)
                                             : 11'($urandom_range(2040, 2047));
            id_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
